// File: rtl/conv1_weight_loader.sv
// Streams signed weights into a kernel buffer and presents one complete KSxKS kernel at a time.
// Define CONV1_WLOAD_DOUBLE_BUF_EN for ping-pong banks; default build is a single FILL/FULL bank.
module conv1_weight_loader #(
    parameter int WW = 9,
    parameter int KS = 5,
    parameter int NK = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_in_valid,
    output logic                  w_in_ready,
    input  logic [WW-1:0]         w_in_data,
    output logic                  k_out_valid,
    input  logic                  k_out_ready,
    output logic [KS*KS*WW-1:0]   k_out_data,
    output logic [2:0]            k_out_idx,
    output logic                  k_out_last,
    output logic                  frame_done
);

    localparam int unsigned TAPS = KS * KS;
    localparam int unsigned TW   = $clog2(TAPS);
    localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NK - 1);

    logic [TW-1:0] tap_cnt_q, tap_cnt_d;
    logic [2:0]    rd_idx_q, rd_idx_d;
    logic          ready_q;
    logic          valid_q;
    logic          frame_done_q;

    logic accept;
    logic take;
    logic last_tap;

    assign accept   = w_in_valid && ready_q;
    assign take     = valid_q && k_out_ready;
    assign last_tap = accept && (tap_cnt_q == TAP_LAST);

    always_comb begin
        tap_cnt_d = tap_cnt_q;
        if (accept) begin
            tap_cnt_d = last_tap ? '0 : tap_cnt_q + 1'b1;
        end
        rd_idx_d = rd_idx_q;
        if (take) begin
            rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt_q    <= '0;
            rd_idx_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tap_cnt_q    <= tap_cnt_d;
            rd_idx_q     <= rd_idx_d;
            frame_done_q <= take && k_out_last;
        end
    end

`ifdef CONV1_WLOAD_DOUBLE_BUF_EN

    logic [WW-1:0] mem_q [2][TAPS];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;

    // A bank being filled is never full and a bank being read is always full, so the
    // set and clear below can never target the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        if (take) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (last_tap) begin
            full_d[wr_bank_q] = 1'b1;
        end
        wr_bank_d = wr_bank_q ^ last_tap;
        rd_bank_d = rd_bank_q ^ take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ready_q   <= !full_d[wr_bank_d];
            valid_q   <= full_d[rd_bank_d];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][tap_cnt_q] <= w_in_data;
        end
    end

    always_comb begin
        k_out_data = '0;
        for (int unsigned t = 0; t < TAPS; t++) begin
            k_out_data[t*WW +: WW] = mem_q[rd_bank_q][t];
        end
    end

`else

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e        state_q;
    logic [WW-1:0] mem_q [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    if (last_tap) begin
                        state_q <= FULL;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_q <= FILL;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[tap_cnt_q] <= w_in_data;
        end
    end

    always_comb begin
        k_out_data = '0;
        for (int unsigned t = 0; t < TAPS; t++) begin
            k_out_data[t*WW +: WW] = mem_q[t];
        end
    end

`endif

    assign w_in_ready  = ready_q;
    assign k_out_valid = valid_q;
    assign k_out_idx   = rd_idx_q;
    assign k_out_last  = valid_q && (rd_idx_q == IDX_LAST);
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv1_weight_loader.sv
// Directed self-checking bench for conv1_weight_loader (single or double-buffered build).
module tb_conv1_weight_loader;

    localparam int WW = 9;
    localparam int KS = 5;
    localparam int NK = 6;
    localparam int KW = KS * KS * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_in_valid = 1'b0;
    logic          w_in_ready;
    logic [WW-1:0] w_in_data = '0;
    logic          k_out_valid;
    logic          k_out_ready = 1'b0;
    logic [KW-1:0] k_out_data;
    logic [2:0]    k_out_idx;
    logic          k_out_last;
    logic          frame_done;

    conv1_weight_loader #(.WW(WW), .KS(KS), .NK(NK)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_in_valid  (w_in_valid),
        .w_in_ready  (w_in_ready),
        .w_in_data   (w_in_data),
        .k_out_valid (k_out_valid),
        .k_out_ready (k_out_ready),
        .k_out_data  (k_out_data),
        .k_out_idx   (k_out_idx),
        .k_out_last  (k_out_last),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    idx;
        logic          last;
        logic [KW-1:0] data;
    } rec_t;

    rec_t kq[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   fd_cyc = -1;
    int   last_take_cyc = -1;
    int   stall_err = 0;
    logic hold_pend = 1'b0;
    logic [KW-1:0] held_data;
    logic [2:0]    held_idx;
    logic          held_last;

    always @(posedge clk) cyc++;

    // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (k_out_valid !== 1'b1 || k_out_data !== held_data ||
                              k_out_idx !== held_idx || k_out_last !== held_last)) begin
                stall_err++;
            end
            if (k_out_valid && k_out_ready) begin
                rec_t r;
                r.idx  = k_out_idx;
                r.last = k_out_last;
                r.data = k_out_data;
                kq.push_back(r);
                if (k_out_last) last_take_cyc = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            hold_pend = k_out_valid && !k_out_ready;
            held_data = k_out_data;
            held_idx  = k_out_idx;
            held_last = k_out_last;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [WW-1:0] wgt(input int s, input int t);
        int v;
        v = s * 37 + t * 11 - 60;
        return v[WW-1:0];
    endfunction

    function automatic logic [KW-1:0] kdata(input int s);
        logic [KW-1:0] d;
        d = '0;
        for (int t = 0; t < KS * KS; t++) d[t*WW +: WW] = wgt(s, t);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WW-1:0] w);
        int n;
        n = 0;
        w_in_data  = w;
        w_in_valid = 1'b1;
        while (!w_in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!w_in_ready) check("push_wait", 256'(w_in_ready), 256'd1);
        tick();
        w_in_valid = 1'b0;
    endtask

    task automatic push_kernel(input int s);
        for (int t = 0; t < KS * KS; t++) push(wgt(s, t));
    endtask

    task automatic wait_kq(input int n);
        int c;
        c = 0;
        while (kq.size() < n && c < 200) begin
            tick();
            c++;
        end
        check("kq_count", 256'(kq.size()), 256'(n));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        w_in_valid  = 1'b0;
        tick();
        check("rst_valid", 256'(k_out_valid), 256'd0);
        check("rst_ready", 256'(w_in_ready), 256'd0);
        check("rst_fdone", 256'(frame_done), 256'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 256'(w_in_ready), 256'd1);
        check("post_rst_valid", 256'(k_out_valid), 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int kb;
        int fb;
        int sb;
        logic done;
        logic [WW-1:0] w;

        // Reset state and weights 0..24 with the consumer always ready
        tick();
        do_reset();
        k_out_ready = 1'b1;
        for (int t = 0; t < 24; t++) push(WW'(t));
        check("t1_valid_before_last", 256'(k_out_valid), 256'd0);
        push(WW'(24));
        check("t1_valid_after_last", 256'(k_out_valid), 256'd1);
        check("t1_tap00", 256'(k_out_data[0 +: WW]), 256'd0);
        check("t1_tap44", 256'(k_out_data[24*WW +: WW]), 256'd24);
        check("t1_idx", 256'(k_out_idx), 256'd0);
        check("t1_last", 256'(k_out_last), 256'd0);
        tick();
        check("t1_valid_after_take", 256'(k_out_valid), 256'd0);

        // Negative weights stored bit-exact
        push(9'h1FD);
        for (int t = 1; t < 24; t++) push(WW'(t));
        push(9'h100);
        check("t2_tap00_neg3", 256'(k_out_data[0 +: WW]), 256'h1FD);
        check("t2_tap44_min", 256'(k_out_data[24*WW +: WW]), 256'h100);
        check("t2_idx", 256'(k_out_idx), 256'd1);
        tick();

        // Back-pressure from the consumer
        k_out_ready = 1'b0;
        push_kernel(10);
        check("t3_valid", 256'(k_out_valid), 256'd1);
        check("t3_idx", 256'(k_out_idx), 256'd2);
        check("t3_data", 256'(k_out_data), 256'(kdata(10)));
`ifdef CONV1_WLOAD_DOUBLE_BUF_EN
        check("t3_ready_one_full", 256'(w_in_ready), 256'd1);
        push_kernel(11);
`endif
        check("t3_ready_low", 256'(w_in_ready), 256'd0);
        repeat (4) tick();
        check("t3_ready_held", 256'(w_in_ready), 256'd0);
        check("t3_valid_held", 256'(k_out_valid), 256'd1);
        check("t3_data_held", 256'(k_out_data), 256'(kdata(10)));
        check("t3_idx_held", 256'(k_out_idx), 256'd2);
        k_out_ready = 1'b1;
        tick();
        check("t3_ready_after_free", 256'(w_in_ready), 256'd1);
`ifdef CONV1_WLOAD_DOUBLE_BUF_EN
        check("t3_second_valid", 256'(k_out_valid), 256'd1);
        check("t3_second_idx", 256'(k_out_idx), 256'd3);
        check("t3_second_data", 256'(k_out_data), 256'(kdata(11)));
        tick();
`endif
        check("t3_valid_drained", 256'(k_out_valid), 256'd0);

        // Full frame of six kernels
        do_reset();
        kb = kq.size();
        fb = fd_cnt;
        k_out_ready = 1'b1;
        for (int k = 0; k < NK; k++) push_kernel(k);
        wait_kq(kb + NK);
        repeat (2) tick();
        for (int k = 0; k < NK; k++) begin
            if (kb + k < kq.size()) begin
                check("frame_idx", 256'(kq[kb+k].idx), 256'(k));
                check("frame_last", 256'(kq[kb+k].last), 256'(k == NK - 1));
                check("frame_data", 256'(kq[kb+k].data), 256'(kdata(k)));
            end
        end
        check("frame_done_count", 256'(fd_cnt - fb), 256'd1);
        check("frame_done_timing", 256'(fd_cyc), 256'(last_take_cyc + 1));
        push_kernel(7);
        wait_kq(kb + NK + 1);
        if (kb + NK < kq.size()) begin
            check("frame_wrap_idx", 256'(kq[kb+NK].idx), 256'd0);
            check("frame_wrap_data", 256'(kq[kb+NK].data), 256'(kdata(7)));
        end

        // Reset part-way through a kernel
        kb = kq.size();
        for (int t = 0; t < 12; t++) push(wgt(20, t));
        check("t5_valid_partial", 256'(k_out_valid), 256'd0);
        rst = 1'b1;
        tick();
        check("t5_valid_in_rst", 256'(k_out_valid), 256'd0);
        check("t5_ready_in_rst", 256'(w_in_ready), 256'd0);
        rst = 1'b0;
        tick();
        check("t5_ready_released", 256'(w_in_ready), 256'd1);
        check("t5_valid_released", 256'(k_out_valid), 256'd0);
        check("t5_no_kernel", 256'(kq.size()), 256'(kb));
        push_kernel(30);
        wait_kq(kb + 1);
        if (kb < kq.size()) begin
            check("t5_idx", 256'(kq[kb].idx), 256'd0);
            check("t5_tap00", 256'(kq[kb].data[0 +: WW]), 256'(wgt(30, 0)));
            check("t5_data", 256'(kq[kb].data), 256'(kdata(30)));
        end

        // Random input gaps and output stalls
        do_reset();
        kb = kq.size();
        sb = stall_err;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < NK; k++) begin
                    for (int t = 0; t < KS * KS; t++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        w = wgt(k, t);
                        push(w);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    k_out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        k_out_ready = 1'b1;
        wait_kq(kb + NK);
        for (int k = 0; k < NK; k++) begin
            if (kb + k < kq.size()) begin
                check("rand_idx", 256'(kq[kb+k].idx), 256'(k));
                check("rand_last", 256'(kq[kb+k].last), 256'(k == NK - 1));
                check("rand_data", 256'(kq[kb+k].data), 256'(kdata(k)));
            end
        end
        check("stall_stability", 256'(stall_err - sb), 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv1_weight_loader.md
CONV1_WEIGHT_LOADER -- requirements
Module: conv1_weight_loader

Interface
REQ-001 SHALL have parameter WW, default 9, meaning the signed weight width in bits.
REQ-002 SHALL have parameter KS, default 5, meaning the kernel side, giving KS*KS = 25 taps per kernel.
REQ-003 SHALL have parameter NK, default 6, meaning the number of kernels per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port w_in_valid  input  1  an upstream weight is present.
REQ-007 SHALL have port w_in_ready  output  1  loader can accept a weight.
REQ-008 SHALL have port w_in_data  input  WW  signed weight.
- Stream order is kernel-outer, row, then column.
REQ-009 SHALL have port k_out_valid  output  1  a complete kernel is presented.
REQ-010 SHALL have port k_out_ready  input  1  downstream conv engine accepts the kernel.
REQ-011 SHALL have port k_out_data  output  KS*KS*WW  tap (r,c) at bits [(r*KS+c)*WW +: WW].
REQ-012 SHALL have port k_out_idx  output  3  kernel index 0..NK-1 of the presented kernel.
REQ-013 SHALL have port k_out_last  output  1  high while k_out_valid and k_out_idx == NK-1.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on the cycle after the last kernel of a frame is accepted.

Function
REQ-015 SHALL accept a weight only on a cycle with w_in_valid && w_in_ready.
- Write it to the fill bank at tap_cnt.
- Increment tap_cnt 0..24.
REQ-016 SHALL store weights bit-exact, with no sign extension, truncation or rounding.
REQ-017 SHALL mark the fill bank full when tap 24 is accepted.
- tap_cnt wraps to 0.
- k_out_valid rises on the next cycle if that bank is the read bank (latency 1 cycle from the last-tap handshake).
REQ-018 SHALL hold k_out_data, k_out_idx and k_out_last stable while k_out_valid && !k_out_ready.
REQ-019 SHALL free the read bank on k_out_valid && k_out_ready.
- k_out_idx advances modulo NK: 5 -> 0.
REQ-020 SHALL drive w_in_ready = !full[fill bank] from registered flags only.
- There is no combinational path from k_out_ready to w_in_ready.
- A bank freed in cycle t is writable from cycle t+1.
REQ-021 SHALL process both events in the same cycle when the last-tap write to one bank coincides with the output handshake of the other bank.
REQ-022 SHALL let idle cycles (w_in_valid low) leave tap_cnt and the bank contents unchanged.
REQ-023 SHALL pulse frame_done for exactly one cycle after a handshake with k_out_last high.

Reset
REQ-024 SHALL, while rst is high, clear tap_cnt, the read/write kernel counters, the bank pointers, all full flags and frame_done.
- k_out_valid = 0.
- w_in_ready = 0.
REQ-025 SHALL discard a partial kernel on reset mid-operation.
- The first 25 weights after release form kernel idx 0.
REQ-026 SHALL leave bank storage contents unreset.
- k_out_data is don't-care while k_out_valid = 0.
REQ-027 SHALL assert w_in_ready on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro CONV1_WLOAD_DOUBLE_BUF_EN defined, implement two ping-pong banks.
- Filling of kernel n+1 overlaps presentation of kernel n.
- w_in_ready falls only when both banks are full.
REQ-029 SHALL, without CONV1_WLOAD_DOUBLE_BUF_EN, implement a single bank with states FILL and FULL.
- In FILL, w_in_ready = 1 and k_out_valid = 0.
- FILL -> FULL on tap 24.
- In FULL, w_in_ready = 0 and k_out_valid = 1.
- FULL -> FILL on the output handshake.

Verification
REQ-030 SHALL cover: 25 back-to-back weights 0..24, k_out_ready = 1 -> k_out_valid exactly 1 cycle after the 25th handshake, tap(4,4) = 24, tap(0,0) = 0, k_out_idx = 0.
REQ-031 SHALL cover: first weight -3 -> k_out_data[8:0] = 9'h1FD.
REQ-032 SHALL cover: k_out_ready held 0 while streaming 50 weights -> with DOUBLE_BUF w_in_ready low after the 50th handshake; without it, low after the 25th; kernel-0 data unchanged throughout.
REQ-033 SHALL cover: a full 150-weight frame, k_out_ready = 1 -> six kernels with idx 0..5, k_out_last only on idx 5, one frame_done pulse, next kernel idx = 0.
REQ-034 SHALL cover: rst asserted after 12 taps -> k_out_valid stays 0; the next 25 weights present as idx 0 with tap(0,0) = the first post-reset weight.
REQ-035 SHALL cover: random w_in_valid gaps and k_out_ready stalls -> the kernel sequence is identical to the gap-free run.
